// File: rtl/btb_pkg.sv
// btb_pkg: shared types and helpers for the set-associative BTB.
//   - branch type encodings (BR_*)
//   - btb_entry_t: one stored entry; fields are sized to the widest supported
//     configuration (TAG_W <= 32, PC_W <= 64, CNT_W <= 8) and the top uses the
//     low bits that its own parameters select.
//   - sat_inc / sat_dec: saturating counter steps for a w-bit counter.
package btb_pkg;

    localparam logic [1:0] BR_COND      = 2'd0;
    localparam logic [1:0] BR_DIR       = 2'd1;
    localparam logic [1:0] BR_INDIR_RAS = 2'd2;
    localparam logic [1:0] BR_INDIR_PC  = 2'd3;

    localparam int ENT_TAG_W = 32;
    localparam int ENT_PC_W  = 64;
    localparam int ENT_CNT_W = 8;

    typedef struct packed {
        logic                 valid;
        logic [ENT_TAG_W-1:0] tag;
        logic [2:0]           pos;
        logic [1:0]           typ;
        logic [ENT_PC_W-1:0]  tar;
        logic [1:0]           ras;
        logic [ENT_CNT_W-1:0] cnt;
    } btb_entry_t;

    function automatic logic [ENT_CNT_W-1:0] sat_inc(input logic [ENT_CNT_W-1:0] c, input int w);
        logic [ENT_CNT_W-1:0] mx;
        mx = ENT_CNT_W'((1 << w) - 1);
        return (c == mx) ? c : c + 1'b1;
    endfunction

    function automatic logic [ENT_CNT_W-1:0] sat_dec(input logic [ENT_CNT_W-1:0] c, input int w);
        // w kept for a symmetric call site; the floor is zero for any width
        if (w < 1) return c;
        return (c == '0) ? c : c - 1'b1;
    endfunction

endpackage

// File: rtl/btb_assoc_victim_sel.sv
// btb_assoc_victim_sel: per-set round-robin victim pointers and allocate-way choice.
//   clock, reset_n : clock, async active-low reset
//   flush_i        : clear every pointer
//   alloc_i        : an allocate is committed into set set_i this cycle
//   set_i          : set being allocated
//   vld_i          : valid bits of the ways of set_i
//   way_o          : lowest invalid way, else the set's pointer
module btb_assoc_victim_sel #(
    parameter int WAYS = 2,
    parameter int SETS = 256,
    localparam int IDX_W = $clog2(SETS),
    localparam int WW    = (WAYS > 1) ? $clog2(WAYS) : 1
) (
    input  logic             clock,
    input  logic             reset_n,
    input  logic             flush_i,
    input  logic             alloc_i,
    input  logic [IDX_W-1:0] set_i,
    input  logic [WAYS-1:0]  vld_i,
    output logic [WW-1:0]    way_o
);

    logic [SETS-1:0][WW-1:0] ptr_q;
    logic                    full;
    logic [WW-1:0]           ptr_nxt;

    assign full    = &vld_i;
    assign ptr_nxt = (ptr_q[set_i] == WW'(WAYS - 1)) ? '0 : ptr_q[set_i] + 1'b1;

    always_comb begin
        way_o = ptr_q[set_i];
        for (int w = WAYS - 1; w >= 0; w--) begin
            if (!vld_i[w]) way_o = WW'(w);
        end
    end

    // Pointer only advances when a live entry is displaced.
    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n)              ptr_q <= '0;
        else if (flush_i)          ptr_q <= '0;
        else if (alloc_i && full)  ptr_q[set_i] <= ptr_nxt;
    end

endmodule

// File: rtl/btb_assoc.sv
// btb_assoc: N-way set-associative branch target buffer.
//   f0_vld_i/pc_f0_i : lookup, result registered on *_f1_o one cycle later
//   flush_i          : invalidate everything (beats allocate and retire)
//   sp_*             : speculative allocate from fetch-1
//   rt_*             : retire training (counter, indirect target)
//   *_f1_o           : hit, way, pos, typ, tar, dir, ras
// Lookups see the post-write state of their set (write-first forwarding).
module btb_assoc
    import btb_pkg::*;
#(
    parameter int WAYS     = 2,
    parameter int SETS     = 256,
    parameter int TAG_W    = 20,
    parameter int PC_W     = 64,
    parameter int CNT_W    = 2,
    parameter int CNT_INIT = 1,
    localparam int IDX_W = $clog2(SETS),
    localparam int WW    = (WAYS > 1) ? $clog2(WAYS) : 1
) (
    input  logic            clock,
    input  logic            reset_n,
    input  logic            f0_vld_i,
    input  logic [PC_W-1:0] pc_f0_i,
    input  logic            flush_i,
    input  logic            sp_we_i,
    input  logic [PC_W-1:0] sp_pc_i,
    input  logic [2:0]      sp_pos_i,
    input  logic [1:0]      sp_typ_i,
    input  logic [PC_W-1:0] sp_tar_i,
    input  logic [1:0]      sp_ras_i,
    input  logic            rt_we_i,
    input  logic [PC_W-1:0] rt_pc_i,
    input  logic            rt_dir_i,
    input  logic [PC_W-1:0] rt_tar_i,
    output logic            hit_f1_o,
    output logic [WW-1:0]   way_f1_o,
    output logic [2:0]      pos_f1_o,
    output logic [1:0]      typ_f1_o,
    output logic [PC_W-1:0] tar_f1_o,
    output logic            dir_f1_o,
    output logic [1:0]      ras_f1_o
);

    function automatic logic [IDX_W-1:0] pc_idx(input logic [PC_W-1:0] pc);
        return pc[IDX_W+1:2];
    endfunction
    function automatic logic [TAG_W-1:0] pc_tag(input logic [PC_W-1:0] pc);
        return pc[IDX_W+1+TAG_W:IDX_W+2];
    endfunction

    logic [IDX_W-1:0] f0_idx, sp_idx, rt_idx;
    logic [TAG_W-1:0] f0_tag, sp_tag, rt_tag;
    assign f0_idx = pc_idx(pc_f0_i);
    assign sp_idx = pc_idx(sp_pc_i);
    assign rt_idx = pc_idx(rt_pc_i);
    assign f0_tag = pc_tag(pc_f0_i);
    assign sp_tag = pc_tag(sp_pc_i);
    assign rt_tag = pc_tag(rt_pc_i);

    btb_entry_t       f0_rd [WAYS];
    btb_entry_t       rt_rd [WAYS];
    logic [WAYS-1:0]  sp_vld, sp_hit, rt_hit;
    logic             alloc_do, rt_do;
    logic [WW-1:0]    alloc_way, rt_way;
    btb_entry_t       alloc_ent, rt_ent;

    // ---------------- way storage ----------------
    for (genvar w = 0; w < WAYS; w++) begin : g_way
        btb_entry_t      mem_q [SETS];
        logic [SETS-1:0] vld_q;

        always_comb begin
            f0_rd[w]       = mem_q[f0_idx];
            f0_rd[w].valid = vld_q[f0_idx];
            rt_rd[w]       = mem_q[rt_idx];
            rt_rd[w].valid = vld_q[rt_idx];
        end
        assign sp_vld[w] = vld_q[sp_idx];
        assign sp_hit[w] = vld_q[sp_idx] && (mem_q[sp_idx].tag[TAG_W-1:0] == sp_tag);
        assign rt_hit[w] = rt_rd[w].valid && (rt_rd[w].tag[TAG_W-1:0] == rt_tag);

        always_ff @(posedge clock or negedge reset_n) begin
            if (!reset_n)                                vld_q <= '0;
            else if (flush_i)                            vld_q <= '0;
            else if (alloc_do && alloc_way == WW'(w))    vld_q[sp_idx] <= 1'b1;
        end

        // rt_do already excludes the same set/way as the allocate.
        always_ff @(posedge clock) begin
            if (alloc_do && alloc_way == WW'(w)) mem_q[sp_idx] <= alloc_ent;
            if (rt_do && rt_way == WW'(w))       mem_q[rt_idx] <= rt_ent;
        end
    end

    // ---------------- allocate ----------------
    assign alloc_do = sp_we_i && !flush_i && !(|sp_hit);

    btb_assoc_victim_sel #(.WAYS(WAYS), .SETS(SETS)) u_victim (
        .clock   (clock),
        .reset_n (reset_n),
        .flush_i (flush_i),
        .alloc_i (alloc_do),
        .set_i   (sp_idx),
        .vld_i   (sp_vld),
        .way_o   (alloc_way)
    );

    always_comb begin
        alloc_ent       = '0;
        alloc_ent.valid = 1'b1;
        alloc_ent.tag   = ENT_TAG_W'(sp_tag);
        alloc_ent.pos   = sp_pos_i;
        alloc_ent.typ   = sp_typ_i;
        alloc_ent.tar   = ENT_PC_W'(sp_tar_i);
        alloc_ent.ras   = sp_ras_i;
        alloc_ent.cnt   = (sp_typ_i == BR_COND) ? ENT_CNT_W'(CNT_INIT)
                                                : ENT_CNT_W'({CNT_W{1'b1}});
    end

    // ---------------- retire ----------------
    always_comb begin
        rt_way = '0;
        for (int w = WAYS - 1; w >= 0; w--) begin
            if (rt_hit[w]) rt_way = WW'(w);
        end
    end

    always_comb begin
        rt_ent = rt_rd[rt_way];
        if (rt_dir_i)                   rt_ent.cnt = sat_inc(rt_ent.cnt, CNT_W);
        else if (rt_ent.typ == BR_COND) rt_ent.cnt = sat_dec(rt_ent.cnt, CNT_W);
        if (rt_dir_i && (rt_ent.typ == BR_INDIR_RAS || rt_ent.typ == BR_INDIR_PC))
            rt_ent.tar = ENT_PC_W'(rt_tar_i);
    end

    assign rt_do = rt_we_i && !flush_i && (|rt_hit) &&
                   !(alloc_do && sp_idx == rt_idx && alloc_way == rt_way);

    // ---------------- lookup with write-first view ----------------
    btb_entry_t      post [WAYS];
    logic [WAYS-1:0] f0_hit;
    logic [WW-1:0]   sel_way;
    btb_entry_t      sel_ent;
    logic            hit_d, dir_d;

    always_comb begin
        f0_hit  = '0;
        sel_way = '0;
        for (int w = 0; w < WAYS; w++) begin
            post[w] = f0_rd[w];
            if (alloc_do && alloc_way == WW'(w) && sp_idx == f0_idx)
                post[w] = alloc_ent;
            else if (rt_do && rt_way == WW'(w) && rt_idx == f0_idx)
                post[w] = rt_ent;
            f0_hit[w] = post[w].valid && (post[w].tag[TAG_W-1:0] == f0_tag);
        end
        for (int w = WAYS - 1; w >= 0; w--) begin
            if (f0_hit[w]) sel_way = WW'(w);
        end
        sel_ent = post[sel_way];
        hit_d   = (|f0_hit) && !flush_i;
        dir_d   = (sel_ent.typ == BR_COND) ? sel_ent.cnt[CNT_W-1] : 1'b1;
    end

    logic unused_bits;
    assign unused_bits = ^{pc_f0_i, sp_pc_i, rt_pc_i, sel_ent};

    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            hit_f1_o <= 1'b0;
            way_f1_o <= '0;
            pos_f1_o <= '0;
            typ_f1_o <= '0;
            tar_f1_o <= '0;
            dir_f1_o <= 1'b0;
            ras_f1_o <= '0;
        end else begin
            hit_f1_o <= f0_vld_i && hit_d;
            if (f0_vld_i && hit_d) begin
                way_f1_o <= sel_way;
                pos_f1_o <= sel_ent.pos;
                typ_f1_o <= sel_ent.typ;
                tar_f1_o <= sel_ent.tar[PC_W-1:0];
                dir_f1_o <= dir_d;
                ras_f1_o <= sel_ent.ras;
            end
        end
    end

endmodule

// File: tb/tb_btb_assoc.sv
// tb_btb_assoc: directed-vector bench for btb_assoc (default parameters).
module tb_btb_assoc;
    import btb_pkg::*;

    logic        clock, reset_n;
    logic        f0_vld_i, flush_i, sp_we_i, rt_we_i, rt_dir_i;
    logic [63:0] pc_f0_i, sp_pc_i, sp_tar_i, rt_pc_i, rt_tar_i;
    logic [2:0]  sp_pos_i;
    logic [1:0]  sp_typ_i, sp_ras_i;
    logic        hit_f1_o, dir_f1_o;
    logic [0:0]  way_f1_o;
    logic [2:0]  pos_f1_o;
    logic [1:0]  typ_f1_o, ras_f1_o;
    logic [63:0] tar_f1_o;

    int checks = 0;
    int failures = 0;

    btb_assoc dut (
        .clock(clock), .reset_n(reset_n), .f0_vld_i(f0_vld_i), .pc_f0_i(pc_f0_i),
        .flush_i(flush_i), .sp_we_i(sp_we_i), .sp_pc_i(sp_pc_i), .sp_pos_i(sp_pos_i),
        .sp_typ_i(sp_typ_i), .sp_tar_i(sp_tar_i), .sp_ras_i(sp_ras_i),
        .rt_we_i(rt_we_i), .rt_pc_i(rt_pc_i), .rt_dir_i(rt_dir_i), .rt_tar_i(rt_tar_i),
        .hit_f1_o(hit_f1_o), .way_f1_o(way_f1_o), .pos_f1_o(pos_f1_o),
        .typ_f1_o(typ_f1_o), .tar_f1_o(tar_f1_o), .dir_f1_o(dir_f1_o), .ras_f1_o(ras_f1_o)
    );

    initial begin
        clock = 1'b0;
        forever #5 clock = ~clock;
    end

    task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
        checks++;
        if (got !== exp) begin
            failures++;
            $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
        end
    endtask

    task automatic clr();
        f0_vld_i = 0; flush_i = 0; sp_we_i = 0; rt_we_i = 0;
    endtask

    task automatic step();
        @(posedge clock);
        #1;
        clr();
    endtask

    task automatic set_lookup(input logic [63:0] pc);
        f0_vld_i = 1; pc_f0_i = pc;
    endtask

    task automatic set_alloc(input logic [63:0] pc, input logic [2:0] pos, input logic [1:0] typ,
                             input logic [63:0] tar, input logic [1:0] ras);
        sp_we_i = 1; sp_pc_i = pc; sp_pos_i = pos; sp_typ_i = typ; sp_tar_i = tar; sp_ras_i = ras;
    endtask

    task automatic set_retire(input logic [63:0] pc, input logic d, input logic [63:0] tar);
        rt_we_i = 1; rt_pc_i = pc; rt_dir_i = d; rt_tar_i = tar;
    endtask

    task automatic lookup(input logic [63:0] pc);
        set_lookup(pc);
        step();
    endtask

    task automatic alloc(input logic [63:0] pc, input logic [2:0] pos, input logic [1:0] typ,
                         input logic [63:0] tar);
        set_alloc(pc, pos, typ, tar, 2'd0);
        step();
    endtask

    bit rt_seq  [8] = '{1, 1, 1, 0, 0, 0, 0, 1};
    bit dir_exp [8] = '{1, 1, 1, 1, 0, 0, 0, 0};

    initial begin
        clr();
        pc_f0_i = 0; sp_pc_i = 0; sp_pos_i = 0; sp_typ_i = 0; sp_tar_i = 0; sp_ras_i = 0;
        rt_pc_i = 0; rt_dir_i = 0; rt_tar_i = 0;
        reset_n = 0;
        #12 reset_n = 1;
        #1;
        chk("rst_hit", hit_f1_o, 0);
        chk("rst_tar", tar_f1_o, 0);

        // cold lookup
        lookup(64'h1000);
        chk("cold_hit", hit_f1_o, 0);
        chk("cold_tar", tar_f1_o, 0);
        chk("cold_pos", pos_f1_o, 0);
        chk("cold_dir", dir_f1_o, 0);

        // allocate then hit
        alloc(64'h1000, 3'd3, BR_COND, 64'h2000);
        lookup(64'h1000);
        chk("alloc_hit", hit_f1_o, 1);
        chk("alloc_tar", tar_f1_o, 64'h2000);
        chk("alloc_pos", pos_f1_o, 3);
        chk("alloc_dir", dir_f1_o, 0);
        chk("alloc_way", way_f1_o, 0);
        chk("alloc_typ", typ_f1_o, BR_COND);

        // counter training incl. both saturation ends
        for (int i = 0; i < 8; i++) begin
            set_retire(64'h1000, rt_seq[i], 64'h9999);
            step();
            lookup(64'h1000);
            chk($sformatf("train_dir%0d", i), dir_f1_o, dir_exp[i]);
        end
        chk("cond_tar_kept", tar_f1_o, 64'h2000);

        // replacement in set 0
        alloc(64'h41000, 3'd0, BR_DIR, 64'h3000);
        alloc(64'h81000, 3'd0, BR_DIR, 64'h4000);
        lookup(64'h1000);
        chk("repl_old_miss", hit_f1_o, 0);
        lookup(64'h41000);
        chk("repl_b_hit", hit_f1_o, 1);
        chk("repl_b_way", way_f1_o, 1);
        chk("repl_b_dir", dir_f1_o, 1);
        lookup(64'h81000);
        chk("repl_c_hit", hit_f1_o, 1);
        chk("repl_c_way", way_f1_o, 0);
        chk("repl_c_tar", tar_f1_o, 64'h4000);
        alloc(64'hC1000, 3'd0, BR_DIR, 64'h5000);
        lookup(64'hC1000);
        chk("ptr_adv_way", way_f1_o, 1);
        lookup(64'h81000);
        chk("ptr_keep_hit", hit_f1_o, 1);

        // forwarding: allocate with same-cycle lookup
        set_lookup(64'h3010);
        set_alloc(64'h3010, 3'd5, BR_INDIR_PC, 64'h4444, 2'd2);
        step();
        chk("fwd_a_hit", hit_f1_o, 1);
        chk("fwd_a_tar", tar_f1_o, 64'h4444);
        chk("fwd_a_pos", pos_f1_o, 5);
        chk("fwd_a_typ", typ_f1_o, BR_INDIR_PC);
        chk("fwd_a_ras", ras_f1_o, 2);
        chk("fwd_a_dir", dir_f1_o, 1);
        // forwarding: retire on the hit way
        set_lookup(64'h3010);
        set_retire(64'h3010, 1'b1, 64'h5550);
        step();
        chk("fwd_b_hit", hit_f1_o, 1);
        chk("fwd_b_tar", tar_f1_o, 64'h5550);

        // allocate and retire to same set/way, with a lookup of the victim
        alloc(64'h20, 3'd0, BR_COND, 64'h100);
        alloc(64'h40020, 3'd0, BR_COND, 64'h200);
        set_lookup(64'h20);
        set_alloc(64'h80020, 3'd1, BR_COND, 64'h300, 2'd0);
        set_retire(64'h20, 1'b1, 64'h777);
        step();
        chk("fwd_c_miss", hit_f1_o, 0);
        lookup(64'h80020);
        chk("same_hit", hit_f1_o, 1);
        chk("same_tar", tar_f1_o, 64'h300);
        chk("same_dir", dir_f1_o, 0);
        chk("same_way", way_f1_o, 0);
        lookup(64'h40020);
        chk("same_other", hit_f1_o, 1);

        // retire miss never allocates
        set_retire(64'hABC00, 1'b1, 64'h1);
        step();
        lookup(64'hABC00);
        chk("rt_miss", hit_f1_o, 0);

        // flush beats allocate; coincident lookup misses
        set_lookup(64'h3010);
        set_alloc(64'h500, 3'd0, BR_DIR, 64'h600, 2'd0);
        flush_i = 1;
        step();
        chk("flush_lkp", hit_f1_o, 0);
        lookup(64'h500);
        chk("flush_noalloc", hit_f1_o, 0);
        lookup(64'h3010);
        chk("flush_inval", hit_f1_o, 0);
        // pointers cleared too: third allocate into set 8 takes way 0
        alloc(64'h20, 3'd0, BR_COND, 64'h100);
        alloc(64'h40020, 3'd0, BR_COND, 64'h200);
        alloc(64'h80020, 3'd0, BR_COND, 64'h300);
        lookup(64'h80020);
        chk("flush_ptr_way", way_f1_o, 0);

        // async reset mid-lookup
        alloc(64'h600, 3'd0, BR_DIR, 64'h700);
        lookup(64'h600);
        chk("pre_rst_hit", hit_f1_o, 1);
        set_lookup(64'h600);
        #2 reset_n = 0;
        #1;
        chk("arst_hit", hit_f1_o, 0);
        chk("arst_tar", tar_f1_o, 0);
        #4 reset_n = 1;
        @(posedge clock);
        #1;
        chk("post_rst_miss", hit_f1_o, 0);
        clr();

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
